// File: rtl/rv_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | rv_ctrl_pkg: shared opcodes, FSM states and mux encodings for    |
// | the multi-cycle RV32I control unit.            Rev 1.0           |
// +------------------------------------------------------------------+
`default_nettype none

package rv_ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [1:0] WB_DM  = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [4:0] BR_NONE = 5'b11111;
  localparam logic [4:0] BR_JUMP = 5'b01111;

  localparam logic OP1_PC  = 1'b0;
  localparam logic OP1_RS1 = 1'b1;
  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] func3;
    logic       subsra;
    logic [4:0] br_op;
    logic       op1_sel;
    logic       op2_sel;
    logic [1:0] wb_sel;
    logic       rf_wr;
    logic       is_load;
    logic       is_store;
    logic       is_jump;
    logic       is_branch;
    logic       illegal;
  } ctrl_t;

  // Bundle that performs no writes and requests no branch.
  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c       = '0;
    c.br_op = BR_NONE;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_decoder.sv
// +------------------------------------------------------------------+
// | rv_decoder: combinational RV32I decode of the instruction word   |
// | into a control bundle; unlisted opcodes flag illegal. Rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module rv_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [6:0] opcode;
  logic [4:0] f_rs1, f_rs2, f_rd;
  logic [2:0] f_func3;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign f_rd        = instr_i[11:7];
  assign f_func3     = instr_i[14:12];
  assign f_rs1       = instr_i[19:15];
  assign f_rs2       = instr_i[24:20];
  assign unused_bits = ^{instr_i[31], instr_i[29:25]};

  always_comb begin
    ctrl_o = ctrl_nop();
    case (opcode)
      OPC_RTYPE: begin
        ctrl_o.rs1     = f_rs1;
        ctrl_o.rs2     = f_rs2;
        ctrl_o.rd      = f_rd;
        ctrl_o.func3   = f_func3;
        ctrl_o.subsra  = instr_i[30];
        ctrl_o.op1_sel = OP1_RS1;
        ctrl_o.op2_sel = OP2_RS2;
        ctrl_o.wb_sel  = WB_ALU;
        ctrl_o.rf_wr   = 1'b1;
      end
      OPC_IALU: begin
        ctrl_o.rs1     = f_rs1;
        ctrl_o.rd      = f_rd;
        ctrl_o.func3   = f_func3;
        // ir[30] is part of the immediate except for shifts-right
        ctrl_o.subsra  = (f_func3 == 3'b101) ? instr_i[30] : 1'b0;
        ctrl_o.op1_sel = OP1_RS1;
        ctrl_o.op2_sel = OP2_IMM;
        ctrl_o.wb_sel  = WB_ALU;
        ctrl_o.rf_wr   = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.rs1     = f_rs1;
        ctrl_o.rd      = f_rd;
        ctrl_o.func3   = f_func3;
        ctrl_o.op1_sel = OP1_RS1;
        ctrl_o.op2_sel = OP2_IMM;
        ctrl_o.wb_sel  = WB_DM;
        ctrl_o.rf_wr   = 1'b1;
        ctrl_o.is_load = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.rs1      = f_rs1;
        ctrl_o.rs2      = f_rs2;
        ctrl_o.func3    = f_func3;
        ctrl_o.op1_sel  = OP1_RS1;
        ctrl_o.op2_sel  = OP2_IMM;
        ctrl_o.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.rs1       = f_rs1;
        ctrl_o.rs2       = f_rs2;
        ctrl_o.br_op     = {2'b00, f_func3};
        ctrl_o.op1_sel   = OP1_PC;
        ctrl_o.op2_sel   = OP2_IMM;
        ctrl_o.is_branch = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.rd      = f_rd;
        ctrl_o.br_op   = BR_JUMP;
        ctrl_o.op1_sel = OP1_PC;
        ctrl_o.op2_sel = OP2_IMM;
        ctrl_o.wb_sel  = WB_PC4;
        ctrl_o.rf_wr   = 1'b1;
        ctrl_o.is_jump = 1'b1;
      end
      OPC_JALR: begin
        ctrl_o.rs1     = f_rs1;
        ctrl_o.rd      = f_rd;
        ctrl_o.br_op   = BR_JUMP;
        ctrl_o.op1_sel = OP1_RS1;
        ctrl_o.op2_sel = OP2_IMM;
        ctrl_o.wb_sel  = WB_PC4;
        ctrl_o.rf_wr   = 1'b1;
        ctrl_o.is_jump = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.rd      = f_rd;
        ctrl_o.op1_sel = OP1_RS1;
        ctrl_o.op2_sel = OP2_IMM;
        ctrl_o.wb_sel  = WB_ALU;
        ctrl_o.rf_wr   = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_o.rd      = f_rd;
        ctrl_o.op1_sel = OP1_PC;
        ctrl_o.op2_sel = OP2_IMM;
        ctrl_o.wb_sel  = WB_ALU;
        ctrl_o.rf_wr   = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv_multicycle_cu.sv
// +------------------------------------------------------------------+
// | rv_multicycle_cu: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack |
// | memories. Define RV_MCU_TRAP_EN to trap on illegal opcodes. 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module rv_multicycle_cu
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [XLEN-1:0]  imem_rdata_i,
  input  logic             imem_ack_i,
  output logic             imem_req_o,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             branch_taken_i,
  output logic [XLEN-1:0]  ir_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic [2:0]       func3_o,
  output logic             subsra_o,
  output logic [4:0]       br_op_o,
  output logic             op1_sel_o,
  output logic             op2_sel_o,
  output logic [1:0]       wb_sel_o,
  output logic             pc_sel_o,
  output logic             pc_we_o,
  output logic             rf_we_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             trap_o
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  ctrl_t            ctrl_q, ctrl_d, dec_ctrl;
  logic             imem_req_q, imem_req_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic             pc_sel_q, pc_sel_d;
  logic             pc_we_q, pc_we_d;
  logic             rf_we_q, rf_we_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             fetch_done;
  logic             unused_illegal;

  rv_decoder u_decoder (
    .instr_i (ir_q[31:0]),
    .ctrl_o  (dec_ctrl)
  );

  // Acks only count while the matching request is actually up.
  assign fetch_done = (state_q == S_FETCH) && imem_req_q && imem_ack_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (fetch_done) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_EXEC;
`ifdef RV_MCU_TRAP_EN
        if (dec_ctrl.illegal) state_d = S_TRAP;
`endif
      end
      S_EXEC:   state_d = (ctrl_q.is_load || ctrl_q.is_store) ? S_MEM : S_WB;
      S_MEM:    if (dmem_req_q && dmem_ack_i) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_TRAP: begin
`ifdef RV_MCU_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are registered against the state being entered.
  always_comb begin
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = dmem_req_d & ctrl_q.is_store;
    pc_we_d    = (state_d == S_WB);
    rf_we_d    = pc_we_d & ctrl_q.rf_wr & (ctrl_q.rd != 5'd0);
    ir_d       = fetch_done ? imem_rdata_i : ir_q;
    ctrl_d     = (state_q == S_DECODE) ? dec_ctrl : ctrl_q;
    pc_sel_d   = pc_sel_q;
    if (state_q == S_EXEC)
      pc_sel_d = ctrl_q.is_jump | (ctrl_q.is_branch & branch_taken_i);
    instret_d  = (state_q == S_WB) ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      ctrl_q     <= ctrl_nop();
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      pc_sel_q   <= 1'b0;
      pc_we_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ctrl_q     <= ctrl_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      pc_sel_q   <= pc_sel_d;
      pc_we_q    <= pc_we_d;
      rf_we_q    <= rf_we_d;
      instret_q  <= instret_d;
    end
  end

`ifdef RV_MCU_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trap_q <= 1'b0;
    else         trap_q <= (state_d == S_TRAP);
  end

  assign trap_o         = trap_q;
  assign unused_illegal = ctrl_q.illegal;
`else
  assign trap_o         = 1'b0;
  assign unused_illegal = ctrl_q.illegal ^ dec_ctrl.illegal;
`endif

  assign imem_req_o = imem_req_q;
  assign dmem_req_o = dmem_req_q;
  assign dmem_we_o  = dmem_we_q;
  assign ir_o       = ir_q;
  assign rs1_o      = ctrl_q.rs1;
  assign rs2_o      = ctrl_q.rs2;
  assign rd_o       = ctrl_q.rd;
  assign func3_o    = ctrl_q.func3;
  assign subsra_o   = ctrl_q.subsra;
  assign br_op_o    = ctrl_q.br_op;
  assign op1_sel_o  = ctrl_q.op1_sel;
  assign op2_sel_o  = ctrl_q.op2_sel;
  assign wb_sel_o   = ctrl_q.wb_sel;
  assign pc_sel_o   = pc_sel_q;
  assign pc_we_o    = pc_we_q;
  assign rf_we_o    = rf_we_q;
  assign instret_o  = instret_q;

endmodule

`default_nettype wire

// File: doc/rv_multicycle_cu.md
# rv_multicycle_cu

Multi-cycle RV32I control unit: the successor to the single-cycle decoder, generalised to datapath width `XLEN` and to memories with variable latency through req/ack handshakes. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states, latches the instruction, and drives the datapath muxes and enables, the branch comparator opcode and a retired-instruction counter. It sits between the instruction and data memory ports and the existing datapath blocks: PC, register file, ALU, branch unit and the mux set.

## Interface
- `XLEN`, 32: datapath/instruction-register width (≥32; instruction taken from bits [31:0]).
- `CNT_W`, 32: width of retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `imem_rdata` in XLEN: instruction word, valid when `imem_ack`=1.
- `imem_ack` in 1: instruction fetch complete.
- `imem_req` out 1: fetch request.
- `dmem_ack` in 1: data access complete.
- `dmem_req` out 1: data access request; `dmem_we` out 1 distinguishes store (1) from load (0).
- `branch_taken` in 1: branch unit result, sampled in EXEC.
- `ir` out XLEN: latched instruction.
- `rs1`, `rs2`, `rd` out 5 each: register indices.
- `func3` out 3, `subsra` out 1: ALU/DM control.
- `br_op` out 5: branch opcode; `5'b11111` = no branch, `5'b01111` = unconditional.
- `op1_sel` out 1: 0 = PC, 1 = rs1.
- `op2_sel` out 1: 0 = rs2, 1 = imm.
- `wb_sel` out 2: 00 = DM, 01 = ALU, 10 = PC+4.
- `pc_sel` out 1: 0 = PC+4, 1 = ALU target.
- `pc_we`, `rf_we` out 1: one-cycle write strobes.
- `instret` out CNT_W: retired-instruction count.
- `trap` out 1: illegal-opcode indication (see Configuration).

## Operation
- State register encodes FETCH, DECODE, EXEC, MEM, WB and TRAP. Reset state is FETCH.
- **FETCH:** `imem_req`=1 until `imem_ack`. On the ack cycle, `ir`←`imem_rdata` and the next state is DECODE.
- **DECODE:** `rs1`/`rs2`/`rd`/`func3`/selects decoded from `ir` using the opcode table below. Next state is EXEC.
  - R-type (0110011): op1 = rs1, op2 = rs2, wb ALU, `subsra` = ir[30].
  - I-ALU (0010011): op1 = rs1, op2 = imm, wb ALU. `subsra` = ir[30] only when func3 = 101, else 0.
  - Load (0000011): op1 = rs1, op2 = imm, wb DM.
  - Store (0100011): `rd`=0, no RF write.
  - Branch (1100011): op1 = PC, op2 = imm, `br_op`={2'b00, func3}.
  - JAL (1101111): op1 = PC. JALR (1100111): op1 = rs1. Both: wb PC+4, `br_op`=01111.
  - LUI (0110111): `rs1`=0, op1 = rs1 (x0, so the result is 0+imm).
  - AUIPC (0010111): op1 = PC.
  - All unused fields are driven to 0.
- **EXEC:** `pc_sel` is latched as 1 for JAL/JALR, `branch_taken` for branches, and 0 otherwise. Loads and stores go to MEM; everything else goes to WB.
- **MEM:** `dmem_req`=1 and `dmem_we`=store until `dmem_ack`, then WB.
- **WB:** `pc_we`=1 for exactly one cycle. `rf_we`=1 iff the instruction writes and `rd`≠0. `instret`+1 (wraps at 2^CNT_W). Next state is FETCH.
- Opcode 0x00 or any unlisted opcode is treated as a NOP: no writes except `pc_we` with `pc_sel`=0; it counts as retired.
- An ack while the corresponding req=0 is ignored.

## Timing
- `imem_req`, `dmem_req` and the state are registered. Decode outputs are registered at the DECODE→EXEC edge and held stable through WB.
- Ack in the same cycle req rises is accepted (zero wait).
- Minimum latency per instruction: 4 cycles for non-memory instructions, 5 for load/store. Each memory wait cycle adds 1.
- `reset` low: asynchronously, all outputs go to 0 except `br_op`=11111, and the state goes to FETCH. First `imem_req`=1 appears in the first cycle after release.
- Reset mid-MEM drops `dmem_req` immediately. No partial `rf_we`/`pc_we` is produced.

## Configuration
- `RV_MCU_TRAP_EN` defined:
  - An illegal opcode in DECODE moves to TRAP.
  - `trap`=1 and all requests and strobes stay 0 until reset.
  - `instret` is not incremented.
- Undefined: illegal opcodes follow the NOP rule and `trap` is tied to 0.

## Structure
- Package `rv_ctrl_pkg` holds:
  - opcode localparams;
  - the state enum;
  - `wb_sel` encodings;
  - `br_op` constants (11111, 01111).
- Sub-module `rv_decoder`: combinational decode of `ir` into a control bundle. The FSM registers its outputs.

## Test plan
- `addi x1,x0,5` (0x00500093), `imem_ack` immediate:
  - `rf_we`=1, `rd`=1, `op2_sel`=1, `wb_sel`=01 in cycle 4;
  - `pc_we`=1 in the same cycle;
  - `instret`=1.
- `lw x2,0(x1)` with `dmem_ack` delayed 3 cycles:
  - `dmem_req` high for 4 cycles with `dmem_we`=0;
  - `wb_sel`=00;
  - total 8 cycles from first `imem_req`.
- `beq` with `branch_taken`=1, then another `beq` with `branch_taken`=0:
  - `pc_sel`=1 then 0;
  - `rf_we` never asserted;
  - `br_op`=00000.
- `jal x1,8`: `wb_sel`=10, `pc_sel`=1, `br_op`=01111, `rf_we`=1.
- `reset` asserted during MEM of `sw`:
  - `dmem_req` drops within the same cycle;
  - no `pc_we`;
  - after release the first fetch restarts and `instret`=0.
- Instruction 0xFFFFFFFF:
  - with `RV_MCU_TRAP_EN`, `trap`=1 persists and `imem_req` stays 0;
  - without it, a NOP is retired and `instret` increments.
